// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states and
// datapath select values.
package mc_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_JUMP  = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  typedef enum logic [3:0] {
    RESET    = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXECUTE  = 4'd7,
    ALU_WB   = 4'd8,
    ADDI_EX  = 4'd9,
    ADDI_WB  = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12
  } mcState;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States that hold the memory port until the access completes
  function automatic logic isMemState(input mcState s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory completion tracker: passes mem_ready through in handshake mode, or
// counts a fixed number of cycles per access otherwise.
module mc_mem_wait #(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned MEM_LATENCY   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inMem,
  input  logic memReady,
  output logic memDone
);

  localparam int unsigned WCNT_W = 4;

  logic [WCNT_W-1:0] wcnt;
  logic              lastWait;

  assign lastWait = (wcnt == WCNT_W'(MEM_LATENCY - 1));
  assign memDone  = MEM_HANDSHAKE ? memReady : lastWait;

  // Counter restarts at every access boundary so back-to-back accesses each wait in full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (!inMem || memDone || MEM_HANDSHAKE) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + WCNT_W'(1);
    end
  end

endmodule

// File: rtl/mc_control.sv
// Moore-style multi-cycle MIPS controller: sequences fetch/decode/execute/
// memory/writeback and drives the shared-ALU, single-memory datapath.
module mc_control
  import mc_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dest,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  mcState          state;
  mcState          nextState;
  logic [OP_W-1:0] opQ;
  logic            memDone;

  mc_mem_wait #(
    .MEM_HANDSHAKE(MEM_HANDSHAKE),
    .MEM_LATENCY  (MEM_LATENCY)
  ) uMemWait (
    .clk     (clk),
    .rst_n   (rst_n),
    .inMem   (isMemState(state)),
    .memReady(mem_ready),
    .memDone (memDone)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET;
    else        state <= nextState;
  end

  // Opcode is only trusted in DECODE; later states work from this copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                opQ <= '0;
    else if (state == DECODE)  opQ <= opcode;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        retired <= '0;
    else if (instr_done && !illegal_op) retired <= retired + CNT_W'(1);
  end

  always_comb begin
    nextState     = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dest      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PC_ALU;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;

    case (state)
      RESET: nextState = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        pc_source = PC_ALU;
        if (memDone) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE:      nextState = EXECUTE;
          OP_ADDI:       nextState = ADDI_EX;
          OP_LW, OP_SW:  nextState = MEM_ADDR;
          OP_BEQ, OP_BNE: nextState = BRANCH;
          OP_JUMP:       nextState = JUMP;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            nextState  = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        nextState = (opQ == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (memDone) nextState = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        nextState  = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (memDone) begin
          instr_done = 1'b1;
          nextState  = FETCH;
        end
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        alu_op    = ALU_FUNCT;
        nextState = ALU_WB;
      end
      ALU_WB: begin
        reg_dest   = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nextState  = FETCH;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        nextState = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nextState  = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_ALUOUT;
        branch_ne     = (opQ == OP_BNE);
        instr_done    = 1'b1;
        nextState     = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PC_JUMP;
        instr_done = 1'b1;
        nextState  = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: handshake, fixed-latency and narrow-counter
// instances driven from shared stimulus.
`timescale 1ns/1ps
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = 6'h00;

  // {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dest, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
  //  illegal_op, instr_done}
  wire [18:0] obs, obsF, obsC;
  wire [31:0] ret, retF;
  wire [3:0]  retC;

  int errors = 0;
  int checks = 0;
  int expRet = 0;

  localparam logic [18:0] V_ZERO    = 19'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] V_FETCH_W = 19'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] V_FETCH_D = 19'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] V_DECODE  = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [18:0] V_ILLEGAL = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_1_1;
  localparam logic [18:0] V_ADDR    = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [18:0] V_MEMRD   = 19'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] V_MEMWB   = 19'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0_1;
  localparam logic [18:0] V_MEMWR_W = 19'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] V_MEMWR_D = 19'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0_1;
  localparam logic [18:0] V_EXEC    = 19'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [18:0] V_ALUWB   = 19'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0_1;
  localparam logic [18:0] V_ADDIWB  = 19'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0_1;
  localparam logic [18:0] V_BEQ     = 19'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0_1;
  localparam logic [18:0] V_BNE     = 19'b0_1_1_0_0_0_0_0_0_0_1_00_01_01_0_1;
  localparam logic [18:0] V_JUMP    = 19'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0_1;

  always #5 clk = ~clk;

  mc_control #(.MEM_HANDSHAKE(1'b1), .MEM_LATENCY(1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(obs[18]), .pc_write_cond(obs[17]), .branch_ne(obs[16]),
    .i_or_d(obs[15]), .mem_read(obs[14]), .mem_write(obs[13]),
    .ir_write(obs[12]), .mem_to_reg(obs[11]), .reg_dest(obs[10]),
    .reg_write(obs[9]), .alu_src_a(obs[8]), .alu_src_b(obs[7:6]),
    .alu_op(obs[5:4]), .pc_source(obs[3:2]), .illegal_op(obs[1]),
    .instr_done(obs[0]), .retired(ret)
  );

  mc_control #(.MEM_HANDSHAKE(1'b0), .MEM_LATENCY(3), .CNT_W(32)) dutF (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(obsF[18]), .pc_write_cond(obsF[17]), .branch_ne(obsF[16]),
    .i_or_d(obsF[15]), .mem_read(obsF[14]), .mem_write(obsF[13]),
    .ir_write(obsF[12]), .mem_to_reg(obsF[11]), .reg_dest(obsF[10]),
    .reg_write(obsF[9]), .alu_src_a(obsF[8]), .alu_src_b(obsF[7:6]),
    .alu_op(obsF[5:4]), .pc_source(obsF[3:2]), .illegal_op(obsF[1]),
    .instr_done(obsF[0]), .retired(retF)
  );

  mc_control #(.MEM_HANDSHAKE(1'b1), .MEM_LATENCY(1), .CNT_W(4)) dutC (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(obsC[18]), .pc_write_cond(obsC[17]), .branch_ne(obsC[16]),
    .i_or_d(obsC[15]), .mem_read(obsC[14]), .mem_write(obsC[13]),
    .ir_write(obsC[12]), .mem_to_reg(obsC[11]), .reg_dest(obsC[10]),
    .reg_write(obsC[9]), .alu_src_a(obsC[8]), .alu_src_b(obsC[7:6]),
    .alu_op(obsC[5:4]), .pc_source(obsC[3:2]), .illegal_op(obsC[1]),
    .instr_done(obsC[0]), .retired(retC)
  );

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00; expRet = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== V_ZERO) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, V_ZERO); end
    checks++;
    if (ret !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", ret); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== V_ZERO) begin errors++; $display("FAIL reset_release_state: got %b expected %b", obs, V_ZERO); end
    @(negedge clk); #1;
    checks++;
    if (obs !== V_FETCH_D) begin errors++; $display("FAIL reset_first_fetch: got %b expected %b", obs, V_FETCH_D); end
  endtask

  task automatic test_rtype();
    logic [18:0] e [4];
    e = '{V_FETCH_D, V_DECODE, V_EXEC, V_ALUWB};
    opcode = 6'h00; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL rtype step %0d: got %b expected %b", i, obs, e[i]); end
    end
    @(negedge clk); #1; expRet++;
    checks++;
    if (ret !== 32'(expRet)) begin errors++; $display("FAIL rtype_retired: got %0d expected %0d", ret, expRet); end
  endtask

  task automatic test_addi();
    logic [18:0] e [4];
    e = '{V_FETCH_D, V_DECODE, V_ADDR, V_ADDIWB};
    opcode = 6'h08; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL addi step %0d: got %b expected %b", i, obs, e[i]); end
    end
    @(negedge clk); #1; expRet++;
    checks++;
    if (ret !== 32'(expRet)) begin errors++; $display("FAIL addi_retired: got %0d expected %0d", ret, expRet); end
  endtask

  // LW with three not-ready cycles in MEM_RD; opcode is disturbed after DECODE
  task automatic test_lw_wait();
    logic [18:0] e [8];
    logic        rdy [8];
    e   = '{V_FETCH_D, V_DECODE, V_ADDR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 6'h23;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy[i];
      if (i >= 2) opcode = 6'h2b;
      #1;
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL lw step %0d: got %b expected %b", i, obs, e[i]); end
    end
    @(negedge clk); mem_ready = 1'b1; #1; expRet++;
    checks++;
    if (ret !== 32'(expRet)) begin errors++; $display("FAIL lw_retired: got %0d expected %0d", ret, expRet); end
  endtask

  // SW with one FETCH wait and one MEM_WR wait under handshake
  task automatic test_sw();
    logic [18:0] e [6];
    logic        rdy [6];
    e   = '{V_FETCH_W, V_FETCH_D, V_DECODE, V_ADDR, V_MEMWR_W, V_MEMWR_D};
    rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    opcode = 6'h2b;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy[i];
      #1;
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL sw step %0d: got %b expected %b", i, obs, e[i]); end
    end
    @(negedge clk); mem_ready = 1'b1; #1; expRet++;
    checks++;
    if (ret !== 32'(expRet)) begin errors++; $display("FAIL sw_retired: got %0d expected %0d", ret, expRet); end
  endtask

  task automatic test_branch_jump();
    logic [5:0]  ops [3];
    logic [18:0] last [3];
    logic [18:0] e;
    ops  = '{6'h04, 6'h05, 6'h02};
    last = '{V_BEQ, V_BNE, V_JUMP};
    mem_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      opcode = ops[j];
      for (int i = 0; i < 3; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        e = (i == 0) ? V_FETCH_D : (i == 1) ? V_DECODE : last[j];
        checks++;
        if (obs !== e) begin errors++; $display("FAIL branch_jump op=%h step %0d: got %b expected %b", ops[j], i, obs, e); end
      end
      @(negedge clk); #1; expRet++;
      checks++;
      if (ret !== 32'(expRet)) begin errors++; $display("FAIL branch_jump_retired op=%h: got %0d expected %0d", ops[j], ret, expRet); end
    end
  endtask

  task automatic test_illegal();
    opcode = 6'h3f; mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== V_FETCH_D) begin errors++; $display("FAIL illegal_fetch: got %b expected %b", obs, V_FETCH_D); end
    @(negedge clk); #1;
    checks++;
    if (obs !== V_ILLEGAL) begin errors++; $display("FAIL illegal_decode: got %b expected %b", obs, V_ILLEGAL); end
    @(negedge clk); #1;
    checks++;
    if (ret !== 32'(expRet)) begin errors++; $display("FAIL illegal_retired: got %0d expected %0d", ret, expRet); end
    checks++;
    if (obs !== V_FETCH_D) begin errors++; $display("FAIL illegal_next_fetch: got %b expected %b", obs, V_FETCH_D); end
  endtask

  // Fixed 3-cycle latency; mem_ready held high to show it is ignored
  task automatic test_fixed_latency();
    logic [18:0] e [8];
    e = '{V_FETCH_W, V_FETCH_W, V_FETCH_D, V_DECODE, V_ADDR, V_MEMWR_W, V_MEMWR_W, V_MEMWR_D};
    rst_n = 1'b0; opcode = 6'h2b; mem_ready = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obsF !== e[i]) begin errors++; $display("FAIL fixed_sw step %0d: got %b expected %b", i, obsF, e[i]); end
    end
    @(negedge clk); #1;
    checks++;
    if (retF !== 32'd1) begin errors++; $display("FAIL fixed_retired: got %0d expected 1", retF); end
  endtask

  task automatic test_wrap();
    logic [3:0] expC;
    rst_n = 1'b0; opcode = 6'h08; mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (retC !== 4'd0) begin errors++; $display("FAIL wrap_reset: got %0d expected 0", retC); end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      repeat (4) @(negedge clk);
      #1;
      expC = 4'(k + 1);
      checks++;
      if (retC !== expC) begin errors++; $display("FAIL wrap_count %0d: got %0d expected %0d", k, retC, expC); end
    end
    checks++;
    if (ret !== 32'd16) begin errors++; $display("FAIL wide_count: got %0d expected 16", ret); end
  endtask

  task automatic test_async_reset();
    opcode = 6'h23; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (obs !== V_MEMRD) begin errors++; $display("FAIL async_pre_memrd: got %b expected %b", obs, V_MEMRD); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== V_ZERO) begin errors++; $display("FAIL async_outputs: got %b expected %b", obs, V_ZERO); end
    checks++;
    if (ret !== 32'd0) begin errors++; $display("FAIL async_retired: got %0d expected 0", ret); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_addi();
    test_lw_wait();
    test_sw();
    test_branch_jump();
    test_illegal();
    test_fixed_latency();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
Multi-cycle successor to the single-cycle MIPS main decoder. A Moore-style FSM sequences each instruction through fetch, decode, execute, memory and writeback, and drives the shared-ALU/single-memory datapath control lines. It supports configurable memory wait handling (ready handshake or fixed latency), a real BNE path, illegal-opcode flagging, and a retired-instruction counter. It sits between the instruction register's opcode field and the multi-cycle datapath.

Parameters:
MEM_HANDSHAKE, 1, 1: memory access completes on mem_ready=1; 0: completes after MEM_LATENCY cycles, mem_ready ignored
MEM_LATENCY, 1, cycles per memory access when MEM_HANDSHAKE=0; legal range 1..15
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instruction[31:26] from the IR; valid from DECODE onward
mem_ready  in  1  memory access done (handshake mode only)
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load when the branch condition holds
branch_ne  out  1  0: condition is ALU zero; 1: condition is !zero
i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
mem_to_reg  out  1  write-back data select: 1 = MDR
reg_dest  out  1  destination select: 1 = rd, 0 = rt
reg_write  out  1  register-file write enable
alu_src_a  out  1  0 = PC, 1 = A register
alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
alu_op  out  2  00 = add, 01 = sub, 10 = use funct
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse on an unsupported opcode
instr_done  out  1  one-cycle pulse on an instruction's final cycle
retired  out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset: asynchronous on rst_n=0. State goes to RESET; op_q, wait counter and retired clear to 0. All outputs are 0 while in RESET. The FSM goes RESET->FETCH on the first clock after rst_n deasserts. Reset mid-instruction aborts it with no further strobes.
- Outputs decode from state; only the done-qualified strobes depend on memory completion. Any signal not listed for a state is 0.
- mem_done: in handshake mode, equals mem_ready. In fixed mode, wcnt counts 0..MEM_LATENCY-1 while in a memory state; mem_done=1 when wcnt==MEM_LATENCY-1; wcnt clears on state exit.
- FETCH:
  - mem_read=1, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only in the mem_done cycle; the FSM stays in FETCH until then.
  - Exit -> DECODE.
- DECODE:
  - alu_src_b=11, alu_op=00 (branch target into ALUOut); latch op_q<=opcode.
  - 0x00->EXECUTE, 0x08->ADDI_EX, 0x23/0x2b->MEM_ADDR, 0x04/0x05->BRANCH, 0x02->JUMP.
  - Any other opcode: illegal_op=1 and instr_done=1 this cycle, next state FETCH, retired not incremented.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; op_q==0x23->MEM_RD, else ->MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1; hold until mem_done, then ->MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dest=0, instr_done=1; ->FETCH.
- MEM_WR: mem_write=1, i_or_d=1; hold until mem_done; instr_done=1 in the done cycle; ->FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; ->ALU_WB.
- ALU_WB: reg_dest=1, reg_write=1, instr_done=1; ->FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00; ->ADDI_WB.
- ADDI_WB: reg_dest=0, reg_write=1, instr_done=1; ->FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=(op_q==0x05), instr_done=1; ->FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1; ->FETCH.
- Latency with no memory wait: R/ADDI 4 cycles, LW 5, SW 4, BEQ/BNE/J 3.
- retired increments on every instr_done except an illegal opcode; it wraps from all-ones to 0.
- opcode changes outside DECODE have no effect, since later states use op_q.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants (RTYPE, ADDI, BEQ, BNE, LW, SW, JUMP);
  - state enum, 4-bit encoding, RESET=0;
  - alu_op, alu_src_b and pc_source encodings.
- One sub-module, mc_mem_wait: the wait counter and mem_done generation, parametrised by MEM_HANDSHAKE and MEM_LATENCY.

Test Plan:
- Reset, then release with MEM_HANDSHAKE=1 and mem_ready=1 -> all outputs 0 in RESET; cycle 1 shows FETCH with mem_read=ir_write=pc_write=1, alu_src_b=01.
- LW (0x23) with mem_ready low 3 cycles in MEM_RD -> mem_read held 4 cycles with i_or_d=1; MEM_WB has reg_write=mem_to_reg=1; retired increments by 1; total 8 cycles.
- BEQ then BNE (0x04, 0x05) -> BRANCH state shows pc_write_cond=1, pc_source=01, branch_ne=0 then 1; each instruction takes 3 cycles.
- Opcode 0x3f -> illegal_op and instr_done pulse in DECODE; retired unchanged; FETCH follows.
- MEM_HANDSHAKE=0, MEM_LATENCY=3, SW (0x2b) -> FETCH lasts 3 cycles with ir_write only in the 3rd; MEM_WR lasts 3 cycles with mem_write=1 throughout.
- CNT_W=4: retire 16 ADDI instructions -> retired goes 15 to 0; rst_n pulled low mid-MEM_RD -> outputs drop to 0 immediately, asynchronously.
